// File: rtl/pipe_stage_reg_pkg.sv
// Shared types and default sizes for the pipeline stage register.
package pipe_stage_reg_pkg;

  // Occupancy state; the encoding doubles as the live-entry count.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_state_e;

  localparam int PSR_DATA_W = 64;
  localparam int PSR_CNT_W  = 8;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating counter that adds 0..2 per cycle and sticks at its maximum.
module sat_counter
  import pipe_stage_reg_pkg::*;
#(
  parameter int W = PSR_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   inc,
  output logic [W-1:0] cnt
);

  localparam int SW = W + 2;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Add in a wider domain so even a 1-bit counter cannot wrap before clamping.
  function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [1:0] b);
    logic [SW-1:0] sum;
    logic [SW-1:0] lim;
    sum = SW'(a) + SW'(b);
    lim = SW'({W{1'b1}});
    if (sum > lim) begin
      return {W{1'b1}};
    end
    return sum[W-1:0];
  endfunction

  // Next count: saturating accumulate of the increment.
  always_comb begin
    cnt_d = sat_add(cnt_q, inc);
  end

  // Count register; reset clears without counting anything.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage: head register plus optional skid register,
// with freeze (stall), flush (discard) and a saturating flush-drop counter.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int DATA_W  = PSR_DATA_W,
  parameter int SKID_EN = 1,
  parameter int CNT_W   = PSR_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  drop_cnt
);

  occ_state_e        state_q;
  occ_state_e        state_d;
  logic [DATA_W-1:0] head_q;
  logic [DATA_W-1:0] head_d;
  logic [DATA_W-1:0] skid_q;
  logic [DATA_W-1:0] skid_d;
  logic              fire_in;
  logic              fire_out;
  logic [1:0]        drop_inc;

  // Handshake decode; in_ready never looks at in_valid.
  always_comb begin
    out_valid = (state_q != OCC_EMPTY);
    fire_out  = out_valid & out_ready & ~freeze & ~flush;
    if (SKID_EN != 0) begin
      in_ready = ~rst & ~freeze & ~flush & (state_q != OCC_FULL);
    end else begin
      // Single entry: only accept into an empty slot or one being vacated now.
      in_ready = ~rst & ~freeze & ~flush & ((state_q == OCC_EMPTY) | fire_out);
    end
    fire_in = in_valid & in_ready;
  end

  // Next-state and payload movement; freeze holds everything by blocking both fires.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = OCC_EMPTY;
      head_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        OCC_EMPTY: begin
          if (fire_in) begin
            state_d = OCC_ONE;
            head_d  = in_data;
          end
        end
        OCC_ONE: begin
          if (fire_in && fire_out) begin
            head_d = in_data;
          end else if (fire_out) begin
            state_d = OCC_EMPTY;
            head_d  = '0;
          end else if (fire_in && (SKID_EN != 0)) begin
            state_d = OCC_FULL;
            skid_d  = in_data;
          end
        end
        OCC_FULL: begin
          if (fire_out) begin
            state_d = OCC_ONE;
            head_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = OCC_EMPTY;
          head_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  // State and payload registers; reset wins over flush and freeze.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OCC_EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

  assign out_data  = head_q;
  assign occupancy = state_q;
  assign drop_inc  = flush ? occupancy : 2'd0;

  sat_counter #(
    .W (CNT_W)
  ) u_drop_cnt (
    .clk (clk),
    .rst (rst),
    .inc (drop_inc),
    .cnt (drop_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances (default, 2-bit counter, no skid)
// driven in lockstep and compared against a FIFO-level reference model.
module tb_pipe_stage_reg;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        flush;
  logic        in_valid;
  logic [63:0] in_data;
  logic        out_ready;

  logic        ir_a, ov_a, ir_b, ov_b, ir_c, ov_c;
  logic [63:0] od_a, od_b, od_c;
  logic [1:0]  occ_a, occ_b, occ_c;
  logic [7:0]  dc_a, dc_c;
  logic [1:0]  dc_b;

  int checks = 0;
  int errors = 0;

  // Reference model: per instance a bounded FIFO of up to two entries.
  logic [63:0] mdat [3][2];
  int mocc  [3] = '{0, 0, 0};
  int mdrop [3] = '{0, 0, 0};
  int mcap  [3] = '{2, 2, 1};
  int mmax  [3] = '{255, 3, 255};

  typedef struct {
    logic        iv;
    logic [63:0] d;
    logic        ordy;
    logic [1:0]  occ;
    logic        ov;
    logic [63:0] od;
    logic        ir;
  } vec_t;

  vec_t tbl [6];

  pipe_stage_reg #(.DATA_W(64), .SKID_EN(1), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(ir_a),
    .out_valid(ov_a), .out_data(od_a), .out_ready(out_ready),
    .occupancy(occ_a), .drop_cnt(dc_a));

  pipe_stage_reg #(.DATA_W(64), .SKID_EN(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(ir_b),
    .out_valid(ov_b), .out_data(od_b), .out_ready(out_ready),
    .occupancy(occ_b), .drop_cnt(dc_b));

  pipe_stage_reg #(.DATA_W(64), .SKID_EN(0), .CNT_W(8)) dut_c (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(ir_c),
    .out_valid(ov_c), .out_data(od_c), .out_ready(out_ready),
    .occupancy(occ_c), .drop_cnt(dc_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic m_ready(input int i);
    if (rst || freeze || flush) return 1'b0;
    if (mcap[i] == 2) return (mocc[i] < 2);
    return (mocc[i] == 0) || out_ready;
  endfunction

  task automatic model_check(input int i, input logic ir, input logic ov,
                             input logic [63:0] od, input logic [1:0] occ,
                             input logic [63:0] dc);
    chk($sformatf("m%0d_in_ready", i), 64'(ir), 64'(m_ready(i)));
    chk($sformatf("m%0d_out_valid", i), 64'(ov), 64'(mocc[i] > 0));
    chk($sformatf("m%0d_out_data", i), od, (mocc[i] > 0) ? mdat[i][0] : 64'd0);
    chk($sformatf("m%0d_occupancy", i), 64'(occ), 64'(mocc[i]));
    chk($sformatf("m%0d_drop_cnt", i), dc, 64'(mdrop[i]));
  endtask

  task automatic model_update();
    for (int i = 0; i < 3; i++) begin
      logic rdy;
      rdy = m_ready(i);
      if (rst) begin
        mocc[i]  = 0;
        mdrop[i] = 0;
      end else if (flush) begin
        mdrop[i] = (mdrop[i] + mocc[i] > mmax[i]) ? mmax[i] : mdrop[i] + mocc[i];
        mocc[i]  = 0;
      end else if (!freeze) begin
        if (mocc[i] > 0 && out_ready) begin
          mdat[i][0] = mdat[i][1];
          mocc[i]--;
        end
        if (in_valid && rdy) begin
          mdat[i][mocc[i]] = in_data;
          mocc[i]++;
        end
      end
    end
  endtask

  // Observe mid-cycle, after inputs have settled.
  task automatic settle();
    @(negedge clk);
    model_check(0, ir_a, ov_a, od_a, occ_a, 64'(dc_a));
    model_check(1, ir_b, ov_b, od_b, occ_b, 64'(dc_b));
    model_check(2, ir_c, ov_c, od_c, occ_c, 64'(dc_c));
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic iv, input logic [63:0] d, input logic ordy);
    rst = 1'b0; freeze = 1'b0; flush = 1'b0;
    in_valid = iv; in_data = d; out_ready = ordy;
  endtask

  initial begin
    tbl[0] = '{iv:1'b1, d:64'hA, ordy:1'b0, occ:2'd0, ov:1'b0, od:64'h0, ir:1'b1};
    tbl[1] = '{iv:1'b1, d:64'hB, ordy:1'b0, occ:2'd1, ov:1'b1, od:64'hA, ir:1'b1};
    tbl[2] = '{iv:1'b0, d:64'h0, ordy:1'b0, occ:2'd2, ov:1'b1, od:64'hA, ir:1'b0};
    tbl[3] = '{iv:1'b0, d:64'h0, ordy:1'b1, occ:2'd2, ov:1'b1, od:64'hA, ir:1'b0};
    tbl[4] = '{iv:1'b0, d:64'h0, ordy:1'b1, occ:2'd1, ov:1'b1, od:64'hB, ir:1'b1};
    tbl[5] = '{iv:1'b0, d:64'h0, ordy:1'b1, occ:2'd0, ov:1'b0, od:64'h0, ir:1'b1};

    rst = 1'b1; freeze = 1'b0; flush = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick();
    tick();

    // Reset state
    set_in(1'b0, 64'h0, 1'b0);
    settle();
    chk("rst_out_valid", 64'(ov_a), 64'd0);
    chk("rst_out_data", od_a, 64'd0);
    chk("rst_occupancy", 64'(occ_a), 64'd0);
    chk("rst_drop_cnt", 64'(dc_a), 64'd0);
    chk("rst_in_ready", 64'(ir_a), 64'd1);
    tick();

    // Fill and drain from the vector table
    for (int r = 0; r < 6; r++) begin
      set_in(tbl[r].iv, tbl[r].d, tbl[r].ordy);
      settle();
      chk($sformatf("fill_occ_r%0d", r), 64'(occ_a), 64'(tbl[r].occ));
      chk($sformatf("fill_ov_r%0d", r), 64'(ov_a), 64'(tbl[r].ov));
      chk($sformatf("fill_od_r%0d", r), od_a, tbl[r].od);
      chk($sformatf("fill_ir_r%0d", r), 64'(ir_a), 64'(tbl[r].ir));
      tick();
    end

    // Streaming 1..10 with one cycle of latency
    for (int k = 1; k <= 10; k++) begin
      set_in(1'b1, 64'(k), 1'b1);
      settle();
      if (k > 1) begin
        chk("stream_data", od_a, 64'(k - 1));
        chk("stream_occ", 64'(occ_a), 64'd1);
      end
      tick();
    end
    set_in(1'b0, 64'h0, 1'b1);
    settle();
    chk("stream_last", od_a, 64'd10);
    tick();

    // Freeze holds the head
    set_in(1'b1, 64'h5, 1'b0);
    settle();
    tick();
    set_in(1'b1, 64'h7, 1'b1);
    freeze = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("frz_data", od_a, 64'h5);
      chk("frz_occ", 64'(occ_a), 64'd1);
      chk("frz_in_ready", 64'(ir_a), 64'd0);
      chk("frz_out_valid", 64'(ov_a), 64'd1);
      tick();
    end
    set_in(1'b0, 64'h0, 1'b1);
    settle();
    chk("frz_release", od_a, 64'h5);
    tick();
    settle();
    chk("frz_drained", 64'(ov_a), 64'd0);
    chk("frz_drained_data", od_a, 64'd0);
    tick();

    // Flush while frozen and full
    set_in(1'b1, 64'h11, 1'b0);
    settle(); tick();
    set_in(1'b1, 64'h22, 1'b0);
    settle(); tick();
    set_in(1'b1, 64'h33, 1'b1);
    freeze = 1'b1; flush = 1'b1;
    settle();
    chk("flush_pre_occ", 64'(occ_a), 64'd2);
    begin
      logic [7:0] prev;
      prev = dc_a;
      tick();
      set_in(1'b0, 64'h0, 1'b0);
      settle();
      chk("flush_occ", 64'(occ_a), 64'd0);
      chk("flush_ov", 64'(ov_a), 64'd0);
      chk("flush_od", od_a, 64'd0);
      chk("flush_drop", 64'(dc_a), 64'(prev + 8'd2));
      chk("flush_drop_noskid", 64'(dc_c), 64'd1);
      tick();
    end

    // Reset while full
    set_in(1'b1, 64'h44, 1'b0);
    settle(); tick();
    set_in(1'b1, 64'h55, 1'b0);
    settle(); tick();
    set_in(1'b1, 64'h66, 1'b1);
    rst = 1'b1;
    settle();
    chk("rstmid_in_ready", 64'(ir_a), 64'd0);
    tick();
    set_in(1'b0, 64'h0, 1'b0);
    settle();
    chk("rstmid_ov", 64'(ov_a), 64'd0);
    chk("rstmid_od", od_a, 64'd0);
    chk("rstmid_occ", 64'(occ_a), 64'd0);
    chk("rstmid_drop", 64'(dc_a), 64'd0);
    chk("rstmid_drop_b", 64'(dc_b), 64'd0);
    chk("rstmid_occ_c", 64'(occ_c), 64'd0);
    tick();

    // Saturation of the 2-bit drop counter
    for (int n = 0; n < 4; n++) begin
      set_in(1'b1, 64'(n * 2 + 1), 1'b0);
      settle(); tick();
      set_in(1'b1, 64'(n * 2 + 2), 1'b0);
      settle(); tick();
      set_in(1'b0, 64'h0, 1'b0);
      flush = 1'b1;
      settle(); tick();
      set_in(1'b0, 64'h0, 1'b0);
      settle();
      chk($sformatf("sat_drop_%0d", n), 64'(dc_b), (n == 0) ? 64'd2 : 64'd3);
      tick();
    end

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 99) == 0);
      freeze    = ($urandom_range(0, 9) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_valid  = $urandom_range(0, 1) == 1;
      in_data   = {$urandom, $urandom};
      out_ready = $urandom_range(0, 3) != 0;
      settle();
      chk("rand_noskid_occ_le1", 64'(occ_c <= 2'd1), 64'd1);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, meaning payload width (PC plus instruction).
REQ-002 The block SHALL have parameter SKID_EN, default 1: 1 gives a two-entry skid stage; 0 gives a single-entry stage.
REQ-003 The block SHALL have parameter CNT_W, default 8, meaning the width of the flush-drop counter.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port freeze, input, 1 bit: stall, blocking transfer in and transfer out.
REQ-007 The block SHALL have port flush, input, 1 bit: discard all held entries.
REQ-008 The block SHALL have port in_valid, input, 1 bit: upstream offers in_data.
REQ-009 The block SHALL have port in_data, input, DATA_W bits: upstream payload.
REQ-010 The block SHALL have port in_ready, output, 1 bit: the stage accepts in_data this cycle.
REQ-011 The block SHALL have port out_valid, output, 1 bit: out_data holds a live entry.
REQ-012 The block SHALL have port out_data, output, DATA_W bits: head entry payload.
REQ-013 The block SHALL have port out_ready, input, 1 bit: downstream accepts out_data.
REQ-014 The block SHALL have port occupancy, output, 2 bits: live entries held, 0 to 2.
REQ-015 The block SHALL have port drop_cnt, output, CNT_W bits: count of live entries discarded by flush.

Function
REQ-016 The block SHALL define fire_in = in_valid & in_ready and fire_out = out_valid & out_ready & ~freeze & ~flush.
REQ-017 The block SHALL drive in_ready = ~freeze & ~flush & (occupancy < 2) when SKID_EN=1, and ~freeze & ~flush & (occupancy==0 | fire_out) when SKID_EN=0; in_ready SHALL NOT depend on in_valid.
REQ-018 The block SHALL hold its state as EMPTY (0 entries), ONE (head only) or FULL (head plus skid, SKID_EN=1 only); occupancy SHALL encode the state.
REQ-019 From EMPTY, fire_in SHALL move the block to ONE with the head loaded from in_data, and out_valid SHALL rise on the next cycle (1-cycle latency).
REQ-020 In ONE, fire_in with fire_out SHALL reload the head and stay in ONE; fire_out alone SHALL go to EMPTY; fire_in alone SHALL go to FULL with the skid loaded.
REQ-021 In FULL, fire_out SHALL move the skid into the head and go to ONE; in_ready SHALL be 0 in FULL.
REQ-022 The block SHALL preserve order: entries SHALL leave in acceptance order, with no loss or duplication outside flush.
REQ-023 While freeze=1 and flush=0, all state, out_data and drop_cnt SHALL hold; out_valid SHALL keep its value but no transfer SHALL occur.
REQ-024 flush=1 SHALL take priority over freeze: next cycle EMPTY, out_data=0, skid=0, and in_data that cycle SHALL be dropped.
REQ-025 On flush, drop_cnt SHALL add the current occupancy and SHALL saturate at 2^CNT_W-1 with no wrap.
REQ-026 On leaving the head, out_data SHALL be 0 when EMPTY; on reaching EMPTY via fire_out, out_data SHALL be cleared to 0.
REQ-027 With SKID_EN=0, FULL SHALL be unreachable and occupancy SHALL never exceed 1.

Reset
REQ-028 rst=1 at a clk edge SHALL force EMPTY, out_valid=0, out_data=0, skid=0, occupancy=0 and drop_cnt=0, with priority over flush and freeze.
REQ-029 Reset asserted mid-transfer SHALL discard the in-flight entries without counting them in drop_cnt; in_ready SHALL be 0 while rst=1.

Structure
REQ-030 A shared package SHALL hold the occupancy-state enum (EMPTY, ONE, FULL) and the default DATA_W and CNT_W constants.
REQ-031 A sub-module sat_counter, parametrised by width, SHALL implement drop_cnt as a saturating add of 0 to 2.
REQ-032 The stage SHALL hold no combinational path from in_data to out_data.

Verification
REQ-033 A bench SHALL cover fill and drain: out_ready=0, push 0xA then 0xB -> occupancy=2, in_ready=0; out_ready=1 -> 0xA then 0xB out in consecutive cycles.
REQ-034 A bench SHALL cover streaming: in_valid=1 and out_ready=1 for 10 cycles with values 1..10 -> out_data 1..10, one cycle late, occupancy staying at 1.
REQ-035 A bench SHALL cover freeze: hold 0x5 at the head, freeze=1 for 3 cycles with out_ready=1 -> out_data=0x5 stays constant, no pop, in_ready=0.
REQ-036 A bench SHALL cover flush during freeze: FULL, freeze=1, flush=1 -> next cycle occupancy=0, out_valid=0, out_data=0, drop_cnt+=2.
REQ-037 A bench SHALL cover saturation: CNT_W=2, four flushes of a FULL stage -> drop_cnt reaches 3 and holds at 3.
REQ-038 A bench SHALL cover reset mid-stream: rst=1 while FULL -> next cycle all outputs are 0 and drop_cnt=0; with SKID_EN=0, the same streams SHALL give occupancy of at most 1.
